mul_spi_master: RTL and testbench
=================================

MUL_SPI_MASTER -- requirements
Module: mul_spi_master

Interface
REQ-001 Parameter NssPosition, default 0: index of the spi.nss bit selecting the target multiplier slave.
REQ-002 Parameter TimeoutCycles, default 16: maximum WAIT-state cycles before abort; used only when MUL_SPI_MASTER_TIMEOUT_EN is defined.
REQ-003 REGISTER_SIZE (N) and MulPacket ({op_2, op_1}, 2N bits) SHALL come from package Isa.
REQ-004 i_clock  input  1  system clock; all logic on its rising edge; the slave uses the same clock; no separate SCLK.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  request pulse; sampled only in IDLE.
REQ-007 i_op_1  input  N  first operand; captured on accepted i_start.
REQ-008 i_op_2  input  N  second operand; captured on accepted i_start.
REQ-009 o_busy  output  1  high in every state except IDLE.
REQ-010 o_done  output  1  one-cycle pulse in DONE.
REQ-011 o_result  output  N  last received product; holds until the next DONE.
REQ-012 o_error  output  1  high with o_done when the transaction aborted.
REQ-013 spi  Spi.MasterSpi  -  drives nss (all bits) and mosi; samples miso.

Function
REQ-014 States: IDLE, START, TRANSMIT, WAIT, RECEIVE, DONE.
REQ-015 IDLE: all nss bits 1, mosi 0; when i_start=1, latch {i_op_2, i_op_1} into a 2N-bit shift register and go to START.
REQ-016 START (1 cycle): nss[NssPosition]=0, mosi=1 (start bit); go to TRANSMIT.
REQ-017 TRANSMIT (exactly 2N cycles): mosi = packet bit k in cycle k, LSB first (bit 0 = op_1[0], bit 2N-1 = op_2[N-1]); after the last bit go to WAIT.
REQ-018 WAIT: mosi=0; when sampled miso=1 (slave ready marker), go to RECEIVE on the next edge.
REQ-019 RECEIVE (exactly N cycles): mosi=0; miso sampled into result bit k in cycle k, LSB first; after bit N-1 go to DONE.
REQ-020 DONE (1 cycle): all nss bits 1, mosi 0, o_done=1, o_result updated; go to IDLE.
REQ-021 nss[NssPosition] SHALL stay 0 continuously from START through the last RECEIVE cycle; other nss bits SHALL remain 1 always.
REQ-022 Latency with a compliant slave: o_done high exactly 3N+4 cycles after the cycle in which i_start is accepted (N=8: 28).
REQ-023 i_start while o_busy=1 SHALL be ignored; operands SHALL not change mid-transaction.
REQ-024 i_start in DONE is ignored; i_start in the IDLE cycle immediately after DONE is accepted (back-to-back).
REQ-025 o_result SHALL equal the low N bits of op_1*op_2 as returned by the slave; no local arithmetic.
REQ-026 o_error=0 in all cases when MUL_SPI_MASTER_TIMEOUT_EN is undefined.

Reset
REQ-027 On i_reset=0, asynchronously: state IDLE, all nss bits 1, mosi 0, o_done 0, o_error 0, o_result 0, o_busy 0, counters and shift registers 0.
REQ-028 Reset mid-transaction aborts with no o_done pulse; master and slave SHALL share i_reset so both restart in sync.

Configuration
REQ-029 Macro MUL_SPI_MASTER_TIMEOUT_EN defined: a WAIT counter, cleared on WAIT entry, aborts after TimeoutCycles cycles without miso=1; go to DONE with o_error=1; o_result keeps its previous value.
REQ-030 Macro MUL_SPI_MASTER_TIMEOUT_EN undefined: no counter; WAIT lasts until miso=1, indefinitely if necessary.

Verification
REQ-031 N=8, op_1=3, op_2=5, compliant slave -> o_done in cycle 28 after start, o_result=15, o_error=0.
REQ-032 op_1=0x10, op_2=0x10 -> o_result=0x00 (truncated); mosi sequence after start bit = 00001000 00001000 (LSB first).
REQ-033 i_start pulsed again in cycle 5 of a 7*9 transaction -> ignored, single o_done, o_result=63.
REQ-034 i_reset low in cycle 10 of TRANSMIT -> nss all 1 same cycle, no o_done; new 2*2 transaction after release -> o_result=4.
REQ-035 MUL_SPI_MASTER_TIMEOUT_EN, TimeoutCycles=16, miso held 0 -> o_done and o_error high 16 cycles after WAIT entry.
REQ-036 Back-to-back 1*1 then 255*255 -> o_result 1 then 0x01, second o_done 29 cycles after the first.

Source files
------------

// File: rtl/mul_spi_master_if.sv
// Shared ISA constants and the single-clock SPI bus used by the multiplier link.
// Latency: n/a (type and wire definitions only).
// Backpressure: n/a; flow control is the slave ready marker on miso.
//
// Package Isa   : REGISTER_SIZE (operand/result width N) and MulPacket {op_2, op_1}.
// Interface Spi : nss (one select per slave, active low), mosi, miso.
//                 There is no SCLK; master and slave share the system clock.
package Isa;
    localparam int REGISTER_SIZE = 8;

    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
    } MulPacket;
endpackage

interface Spi #(
    parameter int NssWidth = 1
);
    logic [NssWidth-1:0] nss;
    logic                mosi;
    logic                miso;

    modport MasterSpi (output nss, output mosi, input miso);
    modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/mul_spi_master.sv
// SPI master that ships {op_2, op_1} to a multiplier slave and returns the low N bits of the product.
// Latency: o_done 3N+4 cycles after an accepted i_start with a compliant slave (28 for N=8).
// Backpressure: i_start is ignored while o_busy; WAIT holds until the slave raises miso.
//
// Ports:
//   i_clock, i_reset (async, active low)
//   i_start, i_op_1, i_op_2  : request pulse and operands, captured only in IDLE
//   o_busy, o_done, o_error  : status; o_done pulses once per transaction, o_error marks an abort
//   o_result                 : last product returned by the slave, held until the next DONE
//   spi                      : nss (only bit NssPosition ever goes low), mosi, miso
// Optional feature: define MUL_SPI_MASTER_TIMEOUT_EN to abort WAIT after TimeoutCycles cycles.
module mul_spi_master #(
    parameter int NssPosition   = 0,
    parameter int TimeoutCycles = 16,
    parameter int NssWidth      = 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [Isa::REGISTER_SIZE-1:0] i_op_1,
    input  logic [Isa::REGISTER_SIZE-1:0] i_op_2,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [Isa::REGISTER_SIZE-1:0] o_result,
    output logic                          o_error,
    Spi.MasterSpi                         spi
);
    localparam int N    = Isa::REGISTER_SIZE;
    localparam int CntW = $clog2(2 * N);
    // nss pattern with only the target slave selected
    localparam logic [NssWidth-1:0] NssSel = ~(NssWidth'(1) << NssPosition);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TRANSMIT,
        S_WAIT,
        S_RECEIVE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2*N-1:0]      r_shift;
    logic [CntW-1:0]     r_cnt;
    logic [N-1:0]        r_rx;
    logic [N-1:0]        r_result;
    logic [NssWidth-1:0] r_nss;
    logic                r_mosi;
    logic                r_done;
    logic                r_error;
    Isa::MulPacket       w_packet;

`ifdef MUL_SPI_MASTER_TIMEOUT_EN
    localparam int ToW = $clog2(TimeoutCycles + 1);
    logic [ToW-1:0] r_wait_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TimeoutCycles;
`endif

    assign w_packet.op_1 = i_op_1;
    assign w_packet.op_2 = i_op_2;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_rx       <= '0;
            r_result   <= '0;
            r_nss      <= '1;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef MUL_SPI_MASTER_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_nss   <= '1;
                    r_mosi  <= 1'b0;
                    if (i_start) begin
                        r_shift <= w_packet;
                        r_state <= S_START;
                        r_nss   <= NssSel;
                        r_mosi  <= 1'b1;            // start bit
                    end
                end
                S_START: begin
                    // present packet bit 0 for the first TRANSMIT cycle
                    r_state <= S_TRANSMIT;
                    r_mosi  <= r_shift[0];
                    r_shift <= {1'b0, r_shift[2*N-1:1]};
                    r_cnt   <= '0;
                end
                S_TRANSMIT: begin
                    if (r_cnt == CntW'(2 * N - 1)) begin
                        r_state    <= S_WAIT;
                        r_mosi     <= 1'b0;
`ifdef MUL_SPI_MASTER_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end else begin
                        r_mosi  <= r_shift[0];
                        r_shift <= {1'b0, r_shift[2*N-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (spi.miso) begin
                        r_state <= S_RECEIVE;
                        r_cnt   <= '0;
                    end
`ifdef MUL_SPI_MASTER_TIMEOUT_EN
                    else if (r_wait_cnt == ToW'(TimeoutCycles - 1)) begin
                        // abort: report error, leave o_result untouched
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_nss   <= '1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                S_RECEIVE: begin
                    // LSB arrives first, so shift in from the top
                    r_rx <= {spi.miso, r_rx[N-1:1]};
                    if (r_cnt == CntW'(N - 1)) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= {spi.miso, r_rx[N-1:1]};
                        r_nss    <= '1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_nss   <= '1;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = r_done;
    assign o_error  = r_error;
    assign o_result = r_result;
    assign spi.nss  = r_nss;
    assign spi.mosi = r_mosi;

endmodule

// File: tb/tb_mul_spi_master.sv
// Self-checking bench for mul_spi_master with a behavioural multiplier slave on the shared clock.
// Latency: checks o_done timing against 3N+4 cycles after acceptance.
// Backpressure: slave can be made silent to exercise the WAIT timeout when that build option is on.
module tb_mul_spi_master;
    localparam int N    = Isa::REGISTER_SIZE;
    localparam int NSSW = 2;
    localparam int POS  = 1;
    localparam int LAT  = 3 * N + 4;
    localparam int BUDGET = 200;

    logic         i_clock;
    logic         i_reset;
    logic         i_start;
    logic [N-1:0] i_op_1;
    logic [N-1:0] i_op_2;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_result;
    logic         o_error;

    Spi #(.NssWidth(NSSW)) u_spi ();

    mul_spi_master #(
        .NssPosition  (POS),
        .TimeoutCycles(16),
        .NssWidth     (NSSW)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_op_1  (i_op_1),
        .i_op_2  (i_op_2),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_result(o_result),
        .o_error (o_error),
        .spi     (u_spi.MasterSpi)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural multiplier slave ----------------
    // Waits for a start bit, collects 2N bits LSB first, idles one cycle,
    // raises the ready marker for one cycle, then returns N product bits.
    int          sl_phase;
    int          sl_cnt;
    logic [2*N-1:0] sl_pkt;
    logic [N-1:0]   sl_prod;
    logic        slave_silent = 1'b0;

    always @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sl_phase = 0;
            sl_cnt   = 0;
            u_spi.miso <= 1'b0;
        end else if (u_spi.nss[POS]) begin
            sl_phase = 0;
            u_spi.miso <= 1'b0;
        end else begin
            case (sl_phase)
                0: if (u_spi.mosi) begin sl_phase = 1; sl_cnt = 0; end
                1: begin
                    sl_pkt[sl_cnt] = u_spi.mosi;
                    sl_cnt++;
                    if (sl_cnt == 2 * N) begin
                        sl_prod  = N'((int'(sl_pkt[N-1:0]) * int'(sl_pkt[2*N-1:N])) % (1 << N));
                        sl_phase = 2;
                    end
                    u_spi.miso <= 1'b0;
                end
                2: if (!slave_silent) begin
                    u_spi.miso <= 1'b1;
                    sl_phase = 3;
                    sl_cnt   = 0;
                end
                default: begin
                    if (sl_cnt < N) begin
                        u_spi.miso <= sl_prod[sl_cnt];
                        sl_cnt++;
                    end else begin
                        u_spi.miso <= 1'b0;
                        sl_phase = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- bus monitors ----------------
    int done_cnt  = 0;
    int err_cnt   = 0;
    int viol      = 0;
    always @(negedge i_clock) begin
        if (i_reset) begin
            if (o_done)  done_cnt++;
            if (o_error) err_cnt++;
            // target select low exactly from START through RECEIVE
            if (u_spi.nss[POS] == (o_busy && !o_done)) viol++;
            if (u_spi.nss[0] !== 1'b1) viol++;
            if (u_spi.nss[POS] && u_spi.mosi) viol++;
        end
    end

    // Drive one request and follow it to o_done. Operands are scrambled while busy,
    // and i_start is re-pulsed at cycle extra_at (if >= 1) to prove both are ignored.
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input int extra_at,
                           output logic [N-1:0] res, output logic err, output int lat);
        @(negedge i_clock);
        i_start = 1'b1; i_op_1 = a; i_op_2 = b;
        @(negedge i_clock);
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < BUDGET) begin
            i_start = (lat == extra_at);
            i_op_1  = N'($urandom);
            i_op_2  = N'($urandom);
            @(negedge i_clock);
            lat++;
        end
        i_start = 1'b0;
        res = o_result;
        err = o_error;
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [N-1:0] res;
        logic         err;
        int           lat;
        int           d0;
        logic [N-1:0] prev;

        vecs[0] = '{8'd3,   8'd5,   8'd15};
        vecs[1] = '{8'h10,  8'h10,  8'h00};
        vecs[2] = '{8'd7,   8'd9,   8'd63};
        vecs[3] = '{8'd255, 8'd255, 8'h01};
        vecs[4] = '{8'd1,   8'd1,   8'd1};
        vecs[5] = '{8'd0,   8'd200, 8'd0};
        vecs[6] = '{8'd12,  8'd12,  8'd144};
        vecs[7] = '{8'd128, 8'd2,   8'd0};

        i_reset = 1'b0; i_start = 1'b0; i_op_1 = '0; i_op_2 = '0;
        #23;
        check("reset_busy",   32'(o_busy),   0);
        check("reset_done",   32'(o_done),   0);
        check("reset_error",  32'(o_error),  0);
        check("reset_result", 32'(o_result), 0);
        check("reset_nss",    32'(u_spi.nss), 32'(2'b11));
        check("reset_mosi",   32'(u_spi.mosi), 0);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);

        // table vectors, including truncation and LSB-first packet order
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, -1, res, err, lat);
            check("vec_result",  32'(res), 32'(vecs[i].exp_res));
            check("vec_latency", 32'(lat), 32'(LAT));
            check("vec_error",   32'(err), 0);
            check("vec_packet",  32'(sl_pkt), 32'({vecs[i].b, vecs[i].a}));
        end

        // o_result holds while idle
        prev = o_result;
        repeat (4) @(negedge i_clock);
        check("result_hold", 32'(o_result), 32'(prev));

        // second i_start mid-transaction is ignored
        d0 = done_cnt;
        run_txn(8'd7, 8'd9, 5, res, err, lat);
        repeat (3) @(negedge i_clock);
        check("ignore_start_result",  32'(res), 63);
        check("ignore_start_latency", 32'(lat), 32'(LAT));
        check("ignore_start_ndone",   32'(done_cnt - d0), 1);
        check("ignore_start_idle",    32'(o_busy), 0);

        // back-to-back: start held through DONE, accepted in the following IDLE cycle
        run_txn(8'd1, 8'd1, -1, res, err, lat);
        check("b2b_first_result", 32'(res), 1);
        i_start = 1'b1; i_op_1 = 8'd255; i_op_2 = 8'd255;
        @(negedge i_clock);
        check("b2b_idle_gap", 32'(o_busy), 0);
        @(negedge i_clock);
        i_start = 1'b0;
        lat = 2;
        check("b2b_started", 32'(o_busy), 1);
        while (!o_done && lat < BUDGET) begin
            @(negedge i_clock);
            lat++;
        end
        check("b2b_second_result", 32'(o_result), 32'h01);
        check("b2b_spacing",       32'(lat), 32'(LAT + 1));

        // reset in TRANSMIT bit 10 aborts without o_done
        @(negedge i_clock);
        i_start = 1'b1; i_op_1 = 8'hAB; i_op_2 = 8'hCD;
        @(negedge i_clock);
        i_start = 1'b0;
        lat = 1;
        while (lat < 12) begin
            @(negedge i_clock);
            lat++;
        end
        d0 = done_cnt;
        i_reset = 1'b0;
        #1;
        check("rst_mid_nss",  32'(u_spi.nss), 32'(2'b11));
        check("rst_mid_busy", 32'(o_busy), 0);
        check("rst_mid_mosi", 32'(u_spi.mosi), 0);
        repeat (3) @(negedge i_clock);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        check("rst_mid_no_done", 32'(done_cnt - d0), 0);
        run_txn(8'd2, 8'd2, -1, res, err, lat);
        check("rst_recover_result",  32'(res), 4);
        check("rst_recover_latency", 32'(lat), 32'(LAT));

        // randomized operands against the arithmetic reference
        for (int i = 0; i < 25; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_txn(N'(a), N'(b), -1, res, err, lat);
            check("rand_result",  32'(res), 32'((a * b) % 256));
            check("rand_latency", 32'(lat), 32'(LAT));
        end

`ifdef MUL_SPI_MASTER_TIMEOUT_EN
        // silent slave: abort 16 cycles after WAIT entry (WAIT entered in cycle 2N+2)
        prev = o_result;
        slave_silent = 1'b1;
        run_txn(8'd9, 8'd9, -1, res, err, lat);
        slave_silent = 1'b0;
        check("timeout_latency", 32'(lat), 32'(2 * N + 2 + 16));
        check("timeout_error",   32'(err), 1);
        check("timeout_result",  32'(res), 32'(prev));
        run_txn(8'd6, 8'd7, -1, res, err, lat);
        check("timeout_recover", 32'(res), 42);
        check("timeout_recover_err", 32'(err), 0);
        check("error_pulses", 32'(err_cnt), 1);
`else
        check("error_pulses", 32'(err_cnt), 0);
`endif

        check("nss_protocol_violations", 32'(viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop if something wedges the sequence above
    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
